// File: rtl/osc_pkg.sv
// Purpose: shared types and constants for the uart_tx requester arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package osc_pkg;

    // Arbiter FSM states: IDLE arbitrates, GRANT forwards one owner's bytes,
    // DRAIN waits out the uart_tx busy lag before the next arbitration.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // uart_tx raises tx_active a cycle or so after tx_start, so DRAIN must
    // not trust a low tx_active on its very first cycle.
    localparam int DRAIN_MIN = 2;

    // Default idle-grant limit in clk cycles (1 ms at 50 MHz).
    localparam int TIMEOUT_CYCLES_DEF = 50000;

    // Index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin winner select among unmasked requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on win/win_vld.
//
// Ports:
//   req      - per-requester request bits
//   mask     - requesters excluded from this arbitration
//   last_idx - index of the previous owner; search starts one above it
//   win      - one-hot winner (all zero when win_vld is low)
//   win_vld  - at least one eligible requester was found
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  win,
    output logic          win_vld
);

    always_comb begin : p_pick
        int idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        // Walk last+1, last+2, ... wrapping; the previous owner is visited
        // last so it only wins again when nobody else is asking.
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last_idx) + off) % N;
            if (!win_vld && req[idx] && !mask[idx]) begin
                win[idx] = 1'b1;
                win_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one uart_tx among N_REQ requesters, one packet per grant.
// Latency: grant one cycle after request; byte forwarded one cycle after req_start.
// Backpressure: losers hold req high and wait; tx_active stretches DRAIN.
//
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN enables the idle-grant
// watchdog (counter, per-requester mask, sticky timeout flag).
//
// Ports:
//   clk, rst             - clock; synchronous active-low reset
//   req/req_start/req_data - per-requester request, byte pulse, byte (slice i = [8i+7:8i])
//   gnt                  - one-hot grant (zero in IDLE and DRAIN)
//   tx_start/tx_data     - registered byte strobe and byte toward uart_tx
//   tx_active            - uart_tx busy flag
//   busy                 - FSM not in IDLE
//   timeout              - sticky watchdog flag (tied 0 without the macro)
module uart_tx_arbiter
    import osc_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_start,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_active,
    output logic               busy,
    output logic               timeout
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state_q, state_nxt;
    logic [IW-1:0]    g_idx, g_nxt;
    logic [IW-1:0]    last_gnt, last_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic             tx_start_nxt;
    logic [7:0]       tx_data_nxt;
    logic [1:0]       drain_cnt, drain_nxt;
    logic [N_REQ-1:0] win;
    logic             win_vld;
    logic [N_REQ-1:0] mask;
    logic             wd_trip;
    logic [7:0]       req_byte [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign req_byte[i] = req_data[8*i +: 8];
    end

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req      (req),
        .mask     (mask),
        .last_idx (last_gnt),
        .win      (win),
        .win_vld  (win_vld)
    );

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            g_idx     <= '0;
            last_gnt  <= IW'(N_REQ - 1);
            drain_cnt <= '0;
        end else begin
            state_q   <= state_nxt;
            gnt       <= gnt_nxt;
            tx_start  <= tx_start_nxt;
            tx_data   <= tx_data_nxt;
            g_idx     <= g_nxt;
            last_gnt  <= last_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        gnt_nxt      = gnt;
        g_nxt        = g_idx;
        last_nxt     = last_gnt;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        drain_nxt    = drain_cnt;
        case (state_q)
            IDLE: begin
                gnt_nxt = '0;
                if (win_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = win;
                    g_nxt     = IW'(onehot_idx(8'(win)));
                end
            end
            GRANT: begin
                // A start pulse in the cycle the owner drops req belongs to
                // no packet and is discarded along with the grant.
                if (!req[g_idx] || wd_trip) begin
                    state_nxt = DRAIN;
                    gnt_nxt   = '0;
                    last_nxt  = g_idx;
                    drain_nxt = '0;
                end else if (req_start[g_idx]) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = req_byte[g_idx];
                end
            end
            DRAIN: begin
                gnt_nxt = '0;
                // drain_cnt counts completed DRAIN cycles before this one.
                if (drain_cnt >= 2'(DRAIN_MIN - 1) && !tx_active) begin
                    state_nxt = IDLE;
                end else if (drain_cnt < 2'(DRAIN_MIN - 1)) begin
                    drain_nxt = drain_cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0]   wd_cnt;
    logic [N_REQ-1:0] mask_q;
    logic             timeout_q;

    // Trips on the GRANT cycle that completes TIMEOUT_CYCLES without a
    // forwarded byte; an in-flight uart_tx frame defers it.
    assign wd_trip = (state_q == GRANT) && req[g_idx] && !tx_active &&
                     (int'(wd_cnt) + 1 >= TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt    <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == IDLE && win_vld) || tx_start_nxt) begin
                wd_cnt <= '0;
            end else if (state_q == GRANT && int'(wd_cnt) < TIMEOUT_CYCLES) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end
            // A masked requester is released once it lets go of req.
            mask_q <= (mask_q & req) | (wd_trip ? gnt : '0);
            if (wd_trip) timeout_q <= 1'b1;
        end
    end

    assign mask    = mask_q;
    assign timeout = timeout_q;
`else
    assign wd_trip = 1'b0;
    assign mask    = '0;
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing uart_tx (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle-grant limit in clk cycles (used only with REQ-030).
REQ-003 SHALL have port clk  input  1  single system clock, 50 MHz; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req  input  N_REQ  per-requester bus request, held high for the whole packet.
REQ-006 SHALL have port req_start  input  N_REQ  per-requester one-cycle byte start pulse.
REQ-007 SHALL have port req_data  input  8*N_REQ  per-requester byte, slice i = bits [8i+7:8i].
REQ-008 SHALL have port gnt  output  N_REQ  one-hot grant, at most one bit set.
REQ-009 SHALL have port tx_start  output  1  start pulse to uart_tx.
REQ-010 SHALL have port tx_data  output  8  byte to uart_tx.
REQ-011 SHALL have port tx_active  input  1  uart_tx busy flag.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port timeout  output  1  sticky flag; cleared only by reset.

Function
REQ-014 SHALL implement three states: IDLE, GRANT, DRAIN.
REQ-015 IDLE: when any req bit is high, SHALL select the winner round-robin, searching from (last_gnt+1) mod N_REQ upward, then SHALL enter GRANT with gnt set on the next edge.
REQ-016 IDLE with all req low SHALL remain in IDLE with gnt = 0.
REQ-017 GRANT: tx_start and tx_data SHALL be registered copies of req_start[g] and req_data[g], giving one cycle of latency.
REQ-018 Start pulses from non-granted requesters SHALL be ignored and never forwarded.
REQ-019 A req_start[g] arriving in the same cycle that req[g] is low SHALL be ignored.
REQ-020 GRANT with req[g] low SHALL drop gnt on the next edge, update last_gnt = g, and enter DRAIN.
REQ-021 DRAIN SHALL last at least 2 cycles, to cover the uart_tx active lag, and SHALL exit to IDLE on the first cycle at or after that minimum in which tx_active is low.
REQ-022 New requests arriving during GRANT or DRAIN SHALL wait; no request is lost while req stays high.
REQ-023 tx_data SHALL hold its last value while tx_start is low.
REQ-024 gnt SHALL be 0 in IDLE and DRAIN.

Reset
REQ-025 While rst is low, on the clock edge: state = IDLE, gnt = 0, tx_start = 0, tx_data = 0, busy = 0, timeout = 0, last_gnt = N_REQ-1 (so requester 0 wins first), and the timeout counter and mask are cleared.
REQ-026 Reset asserted mid-packet SHALL abort the grant immediately, with no DRAIN.
REQ-027 The first arbitration SHALL occur on the first edge after rst returns high.

Configuration
REQ-030 Macro UART_TX_ARB_TIMEOUT_EN SHALL gate the watchdog. When defined:
- a counter SHALL clear on grant entry and on each forwarded tx_start;
- when the counter reaches TIMEOUT_CYCLES in GRANT with tx_active low, the block SHALL force DRAIN and set timeout;
- the offending requester SHALL be masked from arbitration until its req goes low.
REQ-031 When UART_TX_ARB_TIMEOUT_EN is undefined: no counter or mask logic, timeout tied to 0, and a grant is held indefinitely.

Structure
REQ-032 Shared package osc_pkg SHALL hold the state enum typedef (IDLE/GRANT/DRAIN), the DRAIN_MIN = 2 constant, and the default TIMEOUT_CYCLES.
REQ-033 Round-robin selection SHALL be a separate combinational sub-module rr_pick (inputs req, mask and last index; outputs one-hot winner and valid).
REQ-034 The FSM, output registers and watchdog SHALL reside in uart_tx_arbiter.

Verification
REQ-040 Reset, then req = 4'b0001 -> gnt = 4'b0001 one cycle later, busy = 1; req_start[0] with data 8'hA5 -> tx_start = 1, tx_data = 8'hA5 on the next cycle.
REQ-041 req = 4'b1111 held, each requester sending one byte then dropping req -> grants in order 0, 1, 2, 3, 0, with gnt never multi-hot.
REQ-042 While granted to 1, req_start[2] pulses with data 8'h3C -> no tx_start and tx_data unchanged.
REQ-043 req[0] drops with tx_active = 1 for 5 more cycles -> gnt = 0 immediately, busy stays 1 until tx_active falls, then IDLE; pending req[1] granted the next cycle.
REQ-044 Reset pulsed for 1 cycle during GRANT -> all outputs 0 next cycle, and requester 0 wins the next arbitration.
REQ-045 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a granted requester that never starts -> DRAIN after 16 cycles, timeout = 1, and that requester is skipped while its req stays high.
